// File: rtl/riscv_pkg.sv
// Shared RV64I decode definitions: opcodes, funct codes, ALU select codes
// (shared with EX), the output-register state type and immediate extraction.
package riscv_pkg;

  localparam int unsigned RISCV_XLEN = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] RISCV_ALU_ADD = 4'd0;
  localparam logic [3:0] RISCV_ALU_SUB = 4'd1;
  localparam logic [3:0] RISCV_ALU_XOR = 4'd2;
  localparam logic [3:0] RISCV_ALU_OR  = 4'd3;
  localparam logic [3:0] RISCV_ALU_AND = 4'd4;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // I-type immediate, sign-extended to RISCV_XLEN
  function automatic logic [RISCV_XLEN-1:0] imm_i(input logic [31:0] inst);
    return {{(RISCV_XLEN-12){inst[31]}}, inst[31:20]};
  endfunction

  // U-type immediate (upper 20 bits, low 12 zero), sign-extended to RISCV_XLEN
  function automatic logic [RISCV_XLEN-1:0] imm_u(input logic [31:0] inst);
    return {{(RISCV_XLEN-32){inst[31]}}, inst[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Busy bitmap of in-flight destination registers plus the RAW hazard check.
// A writeback in the same cycle already counts as retired (bypass), and a
// source matched by the forwarding inputs is satisfied without stalling.
module id_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       kill_en,
  input  logic [4:0] kill_rd,
  input  logic [4:0] rs1,
  input  logic       rs1_used,
  input  logic [4:0] rs2,
  input  logic       rs2_used,
  input  logic       fwd_valid,
  input  logic [4:0] fwd_rd,
  output logic       fwd1_hit,
  output logic       fwd2_hit,
  output logic       hazard
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] kill_mask;
  logic [NREG-1:0] set_mask;
  logic            rs1_busy;
  logic            rs2_busy;

  assign wb_mask   = wb_valid ? (NREG'(1) << wb_rd)   : '0;
  assign kill_mask = kill_en  ? (NREG'(1) << kill_rd) : '0;
  assign set_mask  = set_en   ? (NREG'(1) << set_rd)  : '0;
  assign busy_eff  = busy & ~wb_mask;

  // Hazard evaluation: x0 is never busy; forwarding satisfies a busy source
  always_comb begin
    rs1_busy = (rs1 != 5'd0) && busy_eff[rs1];
    rs2_busy = (rs2 != 5'd0) && busy_eff[rs2];
    fwd1_hit = fwd_valid && (fwd_rd == rs1) && rs1_busy;
    fwd2_hit = fwd_valid && (fwd_rd == rs2) && rs2_busy;
    hazard   = (rs1_used && rs1_busy && !fwd1_hit) ||
               (rs2_used && rs2_busy && !fwd2_hit);
  end

  // Busy update: clears (writeback, flushed entry) first, then set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy    <= (busy & ~wb_mask & ~kill_mask) | set_mask;
      busy[0] <= 1'b0;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV64I decode stage: decodes one IF instruction per cycle into the EX operand
// bundle held in a one-entry output register, with scoreboard RAW stalls.
// Optional macro RISCV_ID_FWD_EN adds fwd_valid/fwd_rd/fwd_data EX forwarding.
//
// Handshake: IF transfers when if_valid && id_ready; EX transfers when
// ex_valid && ex_ready. ex_valid is never withdrawn and the bundle never changes
// while ex_ready is low, except that flush drops the held entry.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
`ifdef RISCV_ID_FWD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] oprand1,
  output logic [XLEN-1:0] oprand2,
  output logic [7:0]      aluop,
  output logic [3:0]      alusel,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic            ex_illegal,
  output logic [XLEN-1:0] ex_pc
);

`ifndef RISCV_ID_FWD_EN
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = '0;
`endif

  out_state_t      state;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic            rs1_used;
  logic            rs2_used;
  logic            fwd1_hit;
  logic            fwd2_hit;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            dec_legal;
  logic [3:0]      dec_alusel;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic            dec_we;

  assign opcode   = if_inst[6:0];
  assign rd       = if_inst[11:7];
  assign funct3   = if_inst[14:12];
  assign funct7   = if_inst[31:25];
  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];

  assign rs1_used = (opcode == OPC_OP) || (opcode == OPC_OP_IMM);
  assign rs2_used = (opcode == OPC_OP);

  assign id_ready = !rst && !flush && (!ex_valid || ex_ready) && !hazard;
  assign accept   = if_valid && id_ready;

  // Source operand values: x0 reads zero, a forwarded producer overrides the regfile
  always_comb begin
    src1 = '0;
    src2 = '0;
    if (rs1_addr != 5'd0) src1 = fwd1_hit ? fwd_data : rs1_data;
    if (rs2_addr != 5'd0) src2 = fwd2_hit ? fwd_data : rs2_data;
  end

  // Instruction decode into the EX bundle; unsupported encodings give zero operands
  always_comb begin
    dec_legal  = 1'b0;
    dec_alusel = RISCV_ALU_ADD;
    dec_op1    = '0;
    dec_op2    = '0;
    case (opcode)
      OPC_OP: begin
        dec_op1 = src1;
        dec_op2 = src2;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_ADD; end
            F3_XOR:     begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_XOR; end
            F3_OR:      begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_OR;  end
            F3_AND:     begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_AND; end
            default:    dec_legal = 1'b0;
          endcase
        end else if ((funct7 == F7_ALT) && (funct3 == F3_ADD_SUB)) begin
          dec_legal  = 1'b1;
          dec_alusel = RISCV_ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        dec_op1 = src1;
        dec_op2 = XLEN'(imm_i(if_inst));
        case (funct3)
          F3_ADD_SUB: begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_ADD; end
          F3_XOR:     begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_XOR; end
          F3_OR:      begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_OR;  end
          F3_AND:     begin dec_legal = 1'b1; dec_alusel = RISCV_ALU_AND; end
          default:    dec_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op2   = XLEN'(imm_u(if_inst));
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_op1   = if_pc;
        dec_op2   = XLEN'(imm_u(if_inst));
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_alusel = RISCV_ALU_ADD;
      dec_op1    = '0;
      dec_op2    = '0;
    end
  end

  assign dec_we = dec_legal && (rd != 5'd0);

  id_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (accept && dec_we),
    .set_rd    (rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .kill_en   (flush && ex_valid && ex_rd_we),
    .kill_rd   (ex_rd),
    .rs1       (rs1_addr),
    .rs1_used  (rs1_used),
    .rs2       (rs2_addr),
    .rs2_used  (rs2_used),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .hazard    (hazard)
  );

  // Output register FSM: EMPTY/FULL with registered bundle; flush drops the entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OUT_EMPTY;
      ex_valid   <= 1'b0;
      oprand1    <= '0;
      oprand2    <= '0;
      aluop      <= 8'd0;
      alusel     <= RISCV_ALU_ADD;
      ex_rd      <= 5'd0;
      ex_rd_we   <= 1'b0;
      ex_illegal <= 1'b0;
      ex_pc      <= '0;
    end else if (flush) begin
      state    <= OUT_EMPTY;
      ex_valid <= 1'b0;
    end else if (accept) begin
      state      <= OUT_FULL;
      ex_valid   <= 1'b1;
      oprand1    <= dec_op1;
      oprand2    <= dec_op2;
      aluop      <= {1'b0, opcode};
      alusel     <= dec_alusel;
      ex_rd      <= rd;
      ex_rd_we   <= dec_we;
      ex_illegal <= !dec_legal;
      ex_pc      <= if_pc;
    end else if ((state == OUT_FULL) && ex_ready) begin
      state    <= OUT_EMPTY;
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a behavioural reference (busy set, held bundle,
// decode from the instruction rules) compared every cycle, plus literal checks.
module tb_id_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        id_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] oprand1;
  logic [63:0] oprand2;
  logic [7:0]  aluop;
  logic [3:0]  alusel;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic        ex_illegal;
  logic [63:0] ex_pc;
`ifdef RISCV_ID_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
`endif

  int tests = 0;
  int fails = 0;

  logic [63:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  id_stage #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
`ifdef RISCV_ID_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .oprand1(oprand1), .oprand2(oprand2), .aluop(aluop), .alusel(alusel),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_illegal(ex_illegal), .ex_pc(ex_pc)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [7:0]  aluop;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [63:0] pc;
    logic        uses1;
    logic        uses2;
  } bundle_t;

  logic [31:0] mbusy;
  logic        m_valid;
  bundle_t     m_b;
  logic [63:0] exp_q[$];

  function automatic logic m_busy_eff(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (wb_valid && wb_rd == r) return 1'b0;
    return mbusy[r];
  endfunction

  function automatic logic m_fwd_hit(input logic [4:0] r);
`ifdef RISCV_ID_FWD_EN
    return fwd_valid && (fwd_rd == r) && m_busy_eff(r);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] m_src(input logic [4:0] r);
    if (r == 5'd0) return 64'd0;
`ifdef RISCV_ID_FWD_EN
    if (m_fwd_hit(r)) return fwd_data;
`endif
    return rf[r];
  endfunction

  function automatic bundle_t m_decode(input logic [31:0] inst, input logic [63:0] pc);
    bundle_t b;
    logic legal;
    logic [3:0] sel;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    b = '0;
    legal = 1'b0;
    sel = RISCV_ALU_ADD;
    b.aluop = {1'b0, opc};
    b.pc = pc;
    b.rd = inst[11:7];
    b.uses1 = (opc == 7'h33) || (opc == 7'h13);
    b.uses2 = (opc == 7'h33);
    if (opc == 7'h33) begin
      if (f3 == 3'd0 && f7 == 7'h00) begin legal = 1; sel = RISCV_ALU_ADD; end
      else if (f3 == 3'd0 && f7 == 7'h20) begin legal = 1; sel = RISCV_ALU_SUB; end
      else if (f7 == 7'h00 && f3 == 3'd4) begin legal = 1; sel = RISCV_ALU_XOR; end
      else if (f7 == 7'h00 && f3 == 3'd6) begin legal = 1; sel = RISCV_ALU_OR; end
      else if (f7 == 7'h00 && f3 == 3'd7) begin legal = 1; sel = RISCV_ALU_AND; end
      if (legal) begin b.op1 = m_src(inst[19:15]); b.op2 = m_src(inst[24:20]); end
    end else if (opc == 7'h13) begin
      if (f3 == 3'd0) begin legal = 1; sel = RISCV_ALU_ADD; end
      else if (f3 == 3'd4) begin legal = 1; sel = RISCV_ALU_XOR; end
      else if (f3 == 3'd6) begin legal = 1; sel = RISCV_ALU_OR; end
      else if (f3 == 3'd7) begin legal = 1; sel = RISCV_ALU_AND; end
      if (legal) begin b.op1 = m_src(inst[19:15]); b.op2 = 64'($signed(inst[31:20])); end
    end else if (opc == 7'h37) begin
      legal = 1;
      b.op2 = 64'($signed({inst[31:12], 12'h000}));
    end else if (opc == 7'h17) begin
      legal = 1;
      b.op1 = pc;
      b.op2 = 64'($signed({inst[31:12], 12'h000}));
    end
    b.sel = sel;
    b.ill = !legal;
    b.we  = legal && (b.rd != 5'd0);
    return b;
  endfunction

  function automatic logic m_ready();
    bundle_t d;
    logic haz;
    d = m_decode(if_inst, if_pc);
    haz = (d.uses1 && m_busy_eff(if_inst[19:15]) && !m_fwd_hit(if_inst[19:15])) ||
          (d.uses2 && m_busy_eff(if_inst[24:20]) && !m_fwd_hit(if_inst[24:20]));
    return !rst && !flush && (!m_valid || ex_ready) && !haz;
  endfunction

  // Model state update at the active edge from the inputs of the ending cycle
  always @(posedge clk) begin
    logic acc;
    bundle_t nb;
    if (rst) begin
      mbusy = '0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      acc = if_valid && m_ready();
      nb = m_decode(if_inst, if_pc);
      if (flush) begin
        if (m_valid) begin
          if (m_b.we) mbusy[m_b.rd] = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        m_valid = 1'b0;
      end
      if (wb_valid) mbusy[wb_rd] = 1'b0;
      if (acc) begin
        if (nb.we) mbusy[nb.rd] = 1'b1;
        m_b = nb;
        m_valid = 1'b1;
        exp_q.push_back(nb.pc);
      end else if (!flush && m_valid && ex_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare, mid-cycle
  always @(negedge clk) begin
    chk("id_ready", {63'd0, id_ready}, {63'd0, m_ready()});
    if (!rst) begin
      chk("rs1_addr", {59'd0, rs1_addr}, {59'd0, if_inst[19:15]});
      chk("rs2_addr", {59'd0, rs2_addr}, {59'd0, if_inst[24:20]});
      chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
      if (m_valid) begin
        chk("oprand1", oprand1, m_b.op1);
        chk("oprand2", oprand2, m_b.op2);
        chk("aluop", {56'd0, aluop}, {56'd0, m_b.aluop});
        chk("alusel", {60'd0, alusel}, {60'd0, m_b.sel});
        chk("ex_rd", {59'd0, ex_rd}, {59'd0, m_b.rd});
        chk("ex_rd_we", {63'd0, ex_rd_we}, {63'd0, m_b.we});
        chk("ex_illegal", {63'd0, ex_illegal}, {63'd0, m_b.ill});
        chk("ex_pc", ex_pc, m_b.pc);
      end
      if (ex_valid && ex_ready && !flush) begin
        if (exp_q.size() == 0) chk("consume_order_empty", 64'd1, 64'd0);
        else chk("consume_order", ex_pc, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic retire(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd = r;
    cyc();
    wb_valid = 1'b0;
  endtask

  logic [31:0] tbl [8];
  logic [63:0] fwd_val;

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_inst = 32'h00000013; if_pc = '0;
    wb_valid = 1'b0; wb_rd = '0; ex_ready = 1'b1;
`ifdef RISCV_ID_FWD_EN
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
    fwd_val = 64'hDEAD_BEEF_0000_1234;
    for (int i = 0; i < 32; i++) rf[i] = {32'hA5A5_0000 | 32'(i), 32'h0000_1000 + 32'(i)};
    rf[0] = 64'h5555_5555_5555_5555;

    // reset state
    cyc(); cyc();
    if_valid = 1'b1;
    #1;
    chk("rst_id_ready", {63'd0, id_ready}, 64'd0);
    chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_oprand1", oprand1, 64'd0);
    chk("rst_alusel", {60'd0, alusel}, {60'd0, RISCV_ALU_ADD});
    chk("rst_ex_pc", ex_pc, 64'd0);

    // ADDI x1,x0,5
    rst = 1'b0; if_inst = 32'h00500093; if_pc = 64'h0;
    cyc(); if_valid = 1'b0; #1;
    chk("addi_valid", {63'd0, ex_valid}, 64'd1);
    chk("addi_op1", oprand1, 64'd0);
    chk("addi_op2", oprand2, 64'd5);
    chk("addi_rd", {59'd0, ex_rd}, 64'd1);
    chk("addi_we", {63'd0, ex_rd_we}, 64'd1);
    chk("addi_aluop", {56'd0, aluop}, 64'h13);
    retire(5'd1);

    // RAW: ADD x3,x1,x2 then XOR x4,x3,x1
    if_valid = 1'b1; if_inst = 32'h002081B3; if_pc = 64'h10;
    cyc();
    if_inst = 32'h0011C233; if_pc = 64'h14;
    for (int i = 0; i < 3; i++) begin #1; chk("raw_stall", {63'd0, id_ready}, 64'd0); cyc(); end
    wb_valid = 1'b1; wb_rd = 5'd3;
    #1; chk("raw_release", {63'd0, id_ready}, 64'd1);
    cyc(); wb_valid = 1'b0; if_valid = 1'b0; #1;
    chk("raw_op1", oprand1, rf[3]);
    chk("raw_op2", oprand2, rf[1]);
    chk("raw_sel", {60'd0, alusel}, {60'd0, RISCV_ALU_XOR});
    retire(5'd4);

    // backpressure hold, then back-to-back load
    ex_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h00700413; if_pc = 64'h20;
    cyc();
    if_inst = 32'h00F06493; if_pc = 64'h24;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", {63'd0, id_ready}, 64'd0);
      chk("hold_op2", oprand2, 64'd7);
      chk("hold_pc", ex_pc, 64'h20);
      cyc();
    end
    ex_ready = 1'b1;
    #1; chk("hold_release", {63'd0, id_ready}, 64'd1);
    cyc(); if_valid = 1'b0; #1;
    chk("b2b_valid", {63'd0, ex_valid}, 64'd1);
    chk("b2b_op2", oprand2, 64'd15);
    chk("b2b_sel", {60'd0, alusel}, {60'd0, RISCV_ALU_OR});
    chk("b2b_pc", ex_pc, 64'h24);
    retire(5'd8); retire(5'd9);

    // AUIPC x5,0x1 at 0x1000; LUI x6,0x80000
    if_valid = 1'b1; if_inst = 32'h00001297; if_pc = 64'h1000;
    cyc();
    if_inst = 32'h80000337; if_pc = 64'h1004; #1;
    chk("auipc_op1", oprand1, 64'h1000);
    chk("auipc_op2", oprand2, 64'h1000);
    chk("auipc_aluop", {56'd0, aluop}, 64'h17);
    cyc(); if_valid = 1'b0; #1;
    chk("lui_op1", oprand1, 64'd0);
    chk("lui_op2", oprand2, 64'hFFFF_FFFF_8000_0000);
    chk("lui_sel", {60'd0, alusel}, {60'd0, RISCV_ALU_ADD});
    retire(5'd5); retire(5'd6);

    // illegal word, then a reader of x31 must not stall
    if_valid = 1'b1; if_inst = 32'hFFFFFFFF; if_pc = 64'h2000;
    cyc();
    if_inst = 32'h01FF8533; if_pc = 64'h2004; #1;
    chk("ill_flag", {63'd0, ex_illegal}, 64'd1);
    chk("ill_we", {63'd0, ex_rd_we}, 64'd0);
    chk("ill_op2", oprand2, 64'd0);
    chk("ill_no_busy", {63'd0, id_ready}, 64'd1);
    cyc(); if_valid = 1'b0; #1;
    chk("after_ill_op1", oprand1, rf[31]);
    retire(5'd10);

    // mixed encodings with rd=x0, and x0 source reads zero
    tbl[0] = 32'hFFF14013; tbl[1] = 32'h0F01F013; tbl[2] = 32'h0010A013; tbl[3] = 32'h00209033;
    tbl[4] = 32'h0020F033; tbl[5] = 32'h0020E033; tbl[6] = 32'h02208033; tbl[7] = 32'h00100733;
    for (int i = 0; i < 8; i++) begin
      if_valid = 1'b1; if_inst = tbl[i]; if_pc = 64'h3000 + 64'(4 * i);
      cyc();
    end
    if_valid = 1'b0; #1;
    chk("x0_reads_zero", oprand1, 64'd0);
    chk("x0_op2", oprand2, rf[1]);
    retire(5'd14);

    // flush of a held SUB x7 clears busy[7]
    ex_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h402083B3; if_pc = 64'h4000;
    cyc(); #1;
    chk("sub_sel", {60'd0, alusel}, {60'd0, RISCV_ALU_SUB});
    chk("sub_we", {63'd0, ex_rd_we}, 64'd1);
    flush = 1'b1; if_inst = 32'h000385B3; if_pc = 64'h4004;
    #1; chk("flush_ready", {63'd0, id_ready}, 64'd0);
    cyc(); flush = 1'b0; ex_ready = 1'b1; #1;
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_busy_clr", {63'd0, id_ready}, 64'd1);
    cyc(); if_valid = 1'b0; #1;
    chk("post_flush_op1", oprand1, rf[7]);
    retire(5'd11);

`ifdef RISCV_ID_FWD_EN
    // forwarding removes the stall on a busy source
    if_valid = 1'b1; if_inst = 32'h00100613; if_pc = 64'h5000;
    cyc();
    if_inst = 32'h000606B3; if_pc = 64'h5004;
    #1; chk("fwd_stall", {63'd0, id_ready}, 64'd0);
    fwd_valid = 1'b1; fwd_rd = 5'd12; fwd_data = fwd_val;
    #1; chk("fwd_ready", {63'd0, id_ready}, 64'd1);
    cyc(); fwd_valid = 1'b0; if_valid = 1'b0; #1;
    chk("fwd_op1", oprand1, fwd_val);
    retire(5'd12); retire(5'd13);
`endif

    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage feeding the EX ALU: accepts one fetched RV64I instruction per cycle from IF.
- Reads the register file, decodes the instruction into the EX operand bundle (oprand1, oprand2, aluop, alusel) and holds it in a one-entry output register under a valid/ready handshake.
- Tracks in-flight destination registers in a scoreboard and stalls IF on RAW hazards until writeback retires the producer.

Parameters:
XLEN, 64, operand and PC width
NREG, 32, architectural register count; scoreboard width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill the held output entry (branch redirect)
if_valid  in  1  IF offers an instruction
if_inst  in  32  instruction word
if_pc  in  XLEN  instruction PC
id_ready  out  1  stage accepts if_inst this cycle
rs1_addr  out  5  regfile read address 1; combinational from if_inst[19:15]
rs2_addr  out  5  regfile read address 2; combinational from if_inst[24:20]
rs1_data  in  XLEN  regfile read data 1; write-first, same cycle
rs2_data  in  XLEN  regfile read data 2; write-first, same cycle
wb_valid  in  1  writeback retires a register write
wb_rd  in  5  retired destination register
ex_valid  out  1  output bundle valid
ex_ready  in  1  EX consumes the bundle
oprand1  out  XLEN  ALU operand 1
oprand2  out  XLEN  ALU operand 2
aluop  out  8  {1'b0, opcode[6:0]}
alusel  out  4  ALU function select (package code)
ex_rd  out  5  destination register
ex_rd_we  out  1  destination write enable
ex_illegal  out  1  unsupported encoding
ex_pc  out  XLEN  PC of the held instruction

Behaviour:
- Reset (synchronous, rst=1 at clk edge): ex_valid=0; oprand1, oprand2, ex_pc = 0; aluop=0; alusel=ADD; ex_rd=0; ex_rd_we=0; ex_illegal=0; scoreboard busy=0. id_ready is combinational and is 0 while rst=1.
- Hazard:
  - hazard = (rs1 used && busy_eff[rs1]) || (rs2 used && busy_eff[rs2]).
  - busy_eff = busy with the wb_rd bit cleared when wb_valid=1 (same-cycle retire bypass).
  - Register x0 is never busy.
  - rs2 is used only by OP instructions. rs1 is used by OP and OP-IMM.
- id_ready = !rst && !flush && (!ex_valid || ex_ready) && !hazard.
- accept = if_valid && id_ready. On accept the output register loads the decoded bundle; ex_valid=1 next cycle. Latency is 1 cycle.
- Output FSM:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ex_ready && !accept.
  - FULL -> FULL on accept (back-to-back).
  - FULL holds while ex_ready=0; all outputs are stable while held.
- Decode:
  - OP (0110011): ADD/SUB (funct7[5] selects SUB), XOR, OR, AND. oprand1=rs1, oprand2=rs2.
  - OP-IMM (0010011): ADDI, XORI, ORI, ANDI. oprand2 = sign-extended I-imm.
  - LUI: oprand1=0, oprand2=sext(U-imm), alusel=ADD.
  - AUIPC: oprand1=if_pc, oprand2=sext(U-imm), alusel=ADD.
  - Any other encoding: ex_illegal=1, ex_rd_we=0, alusel=ADD, operands 0.
  - ex_rd_we=1 only for legal instructions with rd!=0.
  - Register x0 reads as 0 regardless of rs*_data.
- Scoreboard:
  - On accept with ex_rd_we, set busy[rd].
  - On wb_valid, clear busy[wb_rd].
  - Set and clear of the same register in the same cycle: set wins.
- flush:
  - The held entry is dropped: ex_valid=0 next cycle.
  - If the dropped entry has ex_rd_we=1, its busy bit is cleared.
  - No accept happens in the flush cycle.
  - Instructions already in EX/WB still retire through wb_valid.

Optional Feature:
- Macro: RISCV_ID_FWD_EN.
- When defined, the block adds ports fwd_valid (in, 1), fwd_rd (in, 5) and fwd_data (in, XLEN), driven from the EX result.
- A busy source register matching fwd_rd with fwd_valid=1 is not a hazard; its operand takes fwd_data.
- When undefined, these ports are absent and every busy source stalls until writeback.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP, OP_IMM, LUI, AUIPC);
  - funct3 codes;
  - RISCV_ALU_* alusel codes shared with EX;
  - the immediate-extraction functions.
- Sub-module id_scoreboard: busy bitmap, set/clear/flush-clear logic, and the hazard check.

Test Plan:
- Reset then if_inst=ADDI x1,x0,5 (0x00500093) with ex_ready=1 -> next cycle: ex_valid=1, oprand1=0, oprand2=5, alusel=ADD, ex_rd=1, ex_rd_we=1.
- ADD x3,x1,x2 issued, then XOR x4,x3,x1, with no wb -> id_ready=0 until wb_valid=1 with wb_rd=3. In that cycle the XOR is accepted, using rs1_data as the operand.
- ex_ready=0 for 3 cycles while if_valid=1 -> id_ready=0 and the bundle is held bit-stable; ex_ready=1 -> the next instruction loads with no bubble.
- AUIPC x5,0x1 at pc=0x1000 -> oprand1=0x1000, oprand2=0x1000; LUI x6,0x80000 -> oprand2=0xFFFFFFFF80000000.
- Illegal word 0xFFFFFFFF -> ex_illegal=1, ex_rd_we=0, and the scoreboard is unchanged.
- Hold SUB x7 in the output register, assert flush -> ex_valid=0 next cycle and busy[7]=0. With RISCV_ID_FWD_EN defined: fwd_valid=1, fwd_rd=7 removes the stall on a dependent instruction, which receives oprand=fwd_data.
